// File: rtl/song_pkg.sv
// song_pkg: shared definitions for the song sequencer, the song ROM generator
// and note_player.
//   - default field widths (note, duration, song select, note index)
//   - sequencer state encoding
//   - end-of-song marker value and the {note, duration} ROM entry layout
package song_pkg;

  localparam int NOTE_W_DEF = 6;
  localparam int DUR_W_DEF  = 6;
  localparam int SONG_W_DEF = 2;
  localparam int IDX_W_DEF  = 5;

  // A ROM entry whose duration equals END_DUR terminates the song.
  localparam int END_DUR = 0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_ROM  = 3'd2,
    S_LOAD      = 3'd3,
    S_WAIT_NOTE = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  // ROM entry layout: note in the upper bits, duration in the lower bits.
  typedef struct packed {
    logic [NOTE_W_DEF-1:0] note;
    logic [DUR_W_DEF-1:0]  dur;
  } rom_entry_t;

  function automatic logic [NOTE_W_DEF+DUR_W_DEF-1:0] make_entry(
    input logic [NOTE_W_DEF-1:0] note,
    input logic [DUR_W_DEF-1:0]  dur
  );
    return {note, dur};
  endfunction

  function automatic logic [NOTE_W_DEF-1:0] entry_note(
    input logic [NOTE_W_DEF+DUR_W_DEF-1:0] entry
  );
    return entry[NOTE_W_DEF+DUR_W_DEF-1:DUR_W_DEF];
  endfunction

  function automatic logic [DUR_W_DEF-1:0] entry_dur(
    input logic [NOTE_W_DEF+DUR_W_DEF-1:0] entry
  );
    return entry[DUR_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/song_sequencer.sv
// song_sequencer: walks a synchronous song ROM and hands each {note, duration}
// entry to note_player with a one-cycle load strobe, waiting for the player to
// finish each note before fetching the next one.
//
// Ports
//   clk              in   system clock, rising edge
//   reset            in   asynchronous reset, active low
//   play             in   1 = run, 0 = hold at the next fetch point
//   song             in   song select, sampled while idle
//   rom_addr         out  {song_q, index} to the song ROM
//   rom_data         in   {note, duration}, one cycle after rom_addr
//   note_to_load     out  registered note for note_player
//   duration_to_load out  registered duration for note_player
//   load_new_note    out  one-cycle strobe, fields valid while high
//   done_with_note   in   one-cycle pulse when the current note expires
//   song_done        out  one-cycle pulse at end of song
//   note_index       out  current entry index
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | track song select, index held at 0, wait for play
// S_FETCH     | rom_addr presented to the ROM
// S_WAIT_ROM  | ROM data valid; end marker -> S_DONE, else latch fields
// S_LOAD      | load_new_note high for this cycle
// S_WAIT_NOTE | wait for done_with_note; then held (index advanced)
//             | until play is high
// S_DONE      | song finished; leave on play low or song change
module song_sequencer
  import song_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W  = DUR_W_DEF,
  parameter int SONG_W = SONG_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic [SONG_W-1:0]       song,
  output logic [SONG_W+IDX_W-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note_to_load,
  output logic [DUR_W-1:0]        duration_to_load,
  output logic                    load_new_note,
  input  logic                    done_with_note,
  output logic                    song_done,
  output logic [IDX_W-1:0]        note_index
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic                load_q, load_d;
  logic                done_q, done_d;
  // Set once the current note has expired and index has advanced; the
  // sequencer then only waits for play before fetching the next entry.
  logic                held_q, held_d;

  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
  logic                song_changed;
  logic                index_last;

  assign rom_note     = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur      = rom_data[DUR_W-1:0];
  assign song_changed = (song != song_q);
  assign index_last   = &index_q;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    song_d  = song_q;
    note_d  = note_q;
    dur_d   = dur_q;
    load_d  = 1'b0;
    done_d  = 1'b0;
    held_d  = held_q;

    if (state_q == S_IDLE) begin
      song_d  = song;
      index_d = '0;
      held_d  = 1'b0;
      if (play) state_d = S_FETCH;
    end else if (song_changed) begin
      // Song change beats everything else, including a done_with_note
      // arriving on the same edge.
      state_d = S_IDLE;
      index_d = '0;
      held_d  = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          state_d = S_WAIT_ROM;
          held_d  = 1'b0;
        end
        S_WAIT_ROM: begin
          if (rom_dur == DUR_W'(END_DUR)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            note_d  = rom_note;
            dur_d   = rom_dur;
            load_d  = 1'b1;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          state_d = S_WAIT_NOTE;
        end
        S_WAIT_NOTE: begin
          if (!held_q) begin
            if (done_with_note) begin
              if (index_last) begin
                // Index saturates at the last entry instead of wrapping.
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                index_d = index_q + IDX_W'(1);
                held_d  = 1'b1;
              end
            end
          end else if (play) begin
            state_d = S_FETCH;
            held_d  = 1'b0;
          end
        end
        S_DONE: begin
          if (!play) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          index_d = '0;
          held_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      song_q  <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      song_q  <= song_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      load_q  <= load_d;
      done_q  <= done_d;
      held_q  <= held_d;
    end
  end

  assign rom_addr         = {song_q, index_q};
  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;
  assign load_new_note    = load_q;
  assign song_done        = done_q;
  assign note_index       = index_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a behavioural synchronous song ROM.
// Song 0: {10,2},{22,5},end   Song 1: 32 entries {i+1,i+1}   Song 2: {33,7},{44,9},end
module tb_song_sequencer;
  import song_pkg::*;

  logic        clk;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        load_new_note;
  logic        done_with_note;
  logic        song_done;
  logic [4:0]  note_index;

  int n_checks;
  int n_fail;

  logic [11:0] rom_mem [0:127];

  song_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .song             (song),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .done_with_note   (done_with_note),
    .song_done        (song_done),
    .note_index       (note_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Strobe exclusivity, checked every cycle out of reset.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      n_checks++;
      if ((load_new_note & song_done) !== 1'b0) begin
        n_fail++;
        $display("FAIL strobe_exclusive: load_new_note=%b song_done=%b required not both 1",
                 load_new_note, song_done);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({load_new_note, song_done, rom_addr, note_to_load, duration_to_load, note_index} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_values: load=%b done=%b addr=%0d note=%0d dur=%0d idx=%0d required all 0",
               load_new_note, song_done, rom_addr, note_to_load, duration_to_load, note_index);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    n_checks++;
    if ({load_new_note, note_index} !== 6'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: load=%b idx=%0d required 0/0", load_new_note, note_index);
    end
  endtask

  task automatic test_basic();
    int loads;
    int dones;
    song = 2'd0; play = 1'b0; tick();
    play = 1'b1;
    tick();  // FETCH
    n_checks++;
    if ({load_new_note, rom_addr} !== {1'b0, 7'd0}) begin
      n_fail++;
      $display("FAIL basic_fetch: load=%b addr=%0d required 0/0", load_new_note, rom_addr);
    end
    tick();  // WAIT_ROM
    n_checks++;
    if (load_new_note !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_load: load=%b required 0", load_new_note);
    end
    tick();  // LOAD
    n_checks++;
    if ({load_new_note, note_to_load, duration_to_load} !== {1'b1, 6'd10, 6'd2}) begin
      n_fail++;
      $display("FAIL basic_load0: load=%b note=%0d dur=%0d required 1/10/2",
               load_new_note, note_to_load, duration_to_load);
    end
    tick(); tick();
    n_checks++;
    if (load_new_note !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_strobe_len: load=%b required 0", load_new_note);
    end
    done_with_note = 1'b1; tick(); done_with_note = 1'b0;
    n_checks++;
    if ({note_index, load_new_note} !== {5'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_index_inc: idx=%0d load=%b required 1/0", note_index, load_new_note);
    end
    tick(); tick();
    n_checks++;
    if (load_new_note !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_next_early: load=%b required 0 two cycles after done", load_new_note);
    end
    tick();
    n_checks++;
    if ({load_new_note, note_to_load, duration_to_load} !== {1'b1, 6'd22, 6'd5}) begin
      n_fail++;
      $display("FAIL basic_load1: load=%b note=%0d dur=%0d required 1/22/5",
               load_new_note, note_to_load, duration_to_load);
    end
    tick();
    done_with_note = 1'b1; tick(); done_with_note = 1'b0;
    tick(); tick();
    n_checks++;
    if (song_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_early: song_done=%b required 0", song_done);
    end
    tick();
    n_checks++;
    if ({song_done, load_new_note} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_marker: song_done=%b load=%b required 1/0", song_done, load_new_note);
    end
    loads = 0; dones = 0;
    repeat (6) begin
      tick();
      if (load_new_note === 1'b1) loads++;
      if (song_done === 1'b1) dones++;
    end
    n_checks++;
    if (loads != 0 || dones != 0) begin
      n_fail++;
      $display("FAIL basic_no_replay: loads=%0d extra_done=%0d required 0/0", loads, dones);
    end
    n_checks++;
    if ({note_to_load, duration_to_load, note_index} !== {6'd22, 6'd5, 5'd2}) begin
      n_fail++;
      $display("FAIL basic_hold_fields: note=%0d dur=%0d idx=%0d required 22/5/2",
               note_to_load, duration_to_load, note_index);
    end
    play = 1'b0; tick(); tick();
    n_checks++;
    if (note_index !== 5'd0) begin
      n_fail++;
      $display("FAIL basic_idle_index: idx=%0d required 0", note_index);
    end
  endtask

  task automatic test_pause();
    int loads;
    play = 1'b1; tick(); tick(); tick();
    n_checks++;
    if ({load_new_note, note_to_load} !== {1'b1, 6'd10}) begin
      n_fail++;
      $display("FAIL pause_first_load: load=%b note=%0d required 1/10", load_new_note, note_to_load);
    end
    tick();
    play = 1'b0; tick();
    done_with_note = 1'b1; tick(); done_with_note = 1'b0;
    n_checks++;
    if (rom_addr !== 7'd1) begin
      n_fail++;
      $display("FAIL pause_addr: addr=%0d required 1", rom_addr);
    end
    loads = 0;
    repeat (5) begin
      tick();
      if (load_new_note === 1'b1) loads++;
    end
    n_checks++;
    if (loads != 0 || rom_addr !== 7'd1) begin
      n_fail++;
      $display("FAIL pause_hold: loads=%0d addr=%0d required 0/1", loads, rom_addr);
    end
    play = 1'b1;
    tick(); tick();
    n_checks++;
    if (load_new_note !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_resume_early: load=%b required 0", load_new_note);
    end
    tick();
    n_checks++;
    if ({load_new_note, note_to_load, duration_to_load} !== {1'b1, 6'd22, 6'd5}) begin
      n_fail++;
      $display("FAIL pause_resume_load: load=%b note=%0d dur=%0d required 1/22/5",
               load_new_note, note_to_load, duration_to_load);
    end
    tick();
  endtask

  task automatic test_song_change();
    song = 2'd2; done_with_note = 1'b1; tick(); done_with_note = 1'b0;
    n_checks++;
    if ({note_index, load_new_note, song_done, rom_addr} !== {5'd0, 1'b0, 1'b0, 7'd0}) begin
      n_fail++;
      $display("FAIL change_idle: idx=%0d load=%b done=%b addr=%0d required 0/0/0/0",
               note_index, load_new_note, song_done, rom_addr);
    end
    tick();
    n_checks++;
    if (rom_addr !== {2'd2, 5'd0}) begin
      n_fail++;
      $display("FAIL change_addr: addr=%0d required 64", rom_addr);
    end
    tick(); tick();
    n_checks++;
    if ({load_new_note, note_to_load, duration_to_load} !== {1'b1, 6'd33, 6'd7}) begin
      n_fail++;
      $display("FAIL change_load: load=%b note=%0d dur=%0d required 1/33/7",
               load_new_note, note_to_load, duration_to_load);
    end
    tick();
    play = 1'b0; song = 2'd1; tick(); tick();
    n_checks++;
    if (rom_addr !== {2'd1, 5'd0}) begin
      n_fail++;
      $display("FAIL change_to_song1: addr=%0d required 32", rom_addr);
    end
  endtask

  task automatic test_full_song();
    int loads;
    int dones;
    bit got;
    play = 1'b1;
    for (int i = 0; i < 32; i++) begin
      got = 1'b0;
      for (int c = 0; c < 6 && !got; c++) begin
        tick();
        if (load_new_note === 1'b1) got = 1'b1;
      end
      n_checks++;
      if (!got || note_to_load !== 6'(i + 1) || duration_to_load !== 6'(i + 1)) begin
        n_fail++;
        $display("FAIL full_load_%0d: seen=%0d note=%0d dur=%0d required 1/%0d/%0d",
                 i, got, note_to_load, duration_to_load, i + 1, i + 1);
      end
      tick();
      done_with_note = 1'b1; tick(); done_with_note = 1'b0;
      if (i < 31) begin
        n_checks++;
        if ({song_done, note_index} !== {1'b0, 5'(i + 1)}) begin
          n_fail++;
          $display("FAIL full_index_%0d: done=%b idx=%0d required 0/%0d", i, song_done, note_index, i + 1);
        end
      end else begin
        n_checks++;
        if ({song_done, note_index} !== {1'b1, 5'd31}) begin
          n_fail++;
          $display("FAIL full_last: done=%b idx=%0d required 1/31", song_done, note_index);
        end
      end
    end
    loads = 0; dones = 0;
    repeat (6) begin
      tick();
      if (load_new_note === 1'b1) loads++;
      if (song_done === 1'b1) dones++;
    end
    n_checks++;
    if (loads != 0 || dones != 0 || note_index !== 5'd31 || rom_addr !== {2'd1, 5'd31}) begin
      n_fail++;
      $display("FAIL full_after: loads=%0d dones=%0d idx=%0d addr=%0d required 0/0/31/63",
               loads, dones, note_index, rom_addr);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    play = 1'b0; song = 2'd0; tick(); tick();
    play = 1'b1; tick(); tick(); tick();
    n_checks++;
    if ({load_new_note, note_to_load} !== {1'b1, 6'd10}) begin
      n_fail++;
      $display("FAIL rstmid_pre_load: load=%b note=%0d required 1/10", load_new_note, note_to_load);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({load_new_note, song_done, rom_addr, note_to_load, duration_to_load, note_index} !== 26'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: load=%b done=%b addr=%0d note=%0d dur=%0d idx=%0d required all 0",
               load_new_note, song_done, rom_addr, note_to_load, duration_to_load, note_index);
    end
    tick();
    n_checks++;
    if ({load_new_note, rom_addr, note_to_load} !== 14'd0) begin
      n_fail++;
      $display("FAIL rstmid_hold: load=%b addr=%0d note=%0d required 0/0/0", load_new_note, rom_addr, note_to_load);
    end
    reset = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      tick();
      if (load_new_note === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got || {note_to_load, duration_to_load, note_index} !== {6'd10, 6'd2, 5'd0}) begin
      n_fail++;
      $display("FAIL rstmid_restart: seen=%0d note=%0d dur=%0d idx=%0d required 1/10/2/0",
               got, note_to_load, duration_to_load, note_index);
    end
  endtask

  task automatic test_spurious();
    int loads;
    tick();
    reset = 1'b0; #1; reset = 1'b1;
    play = 1'b0;
    done_with_note = 1'b1; tick(); done_with_note = 1'b0; tick();
    n_checks++;
    if ({note_index, load_new_note} !== {5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL spur_idle: idx=%0d load=%b required 0/0", note_index, load_new_note);
    end
    play = 1'b1; tick(); tick();
    done_with_note = 1'b1; tick(); done_with_note = 1'b0;
    n_checks++;
    if ({load_new_note, note_to_load, duration_to_load, note_index} !== {1'b1, 6'd10, 6'd2, 5'd0}) begin
      n_fail++;
      $display("FAIL spur_waitrom: load=%b note=%0d dur=%0d idx=%0d required 1/10/2/0",
               load_new_note, note_to_load, duration_to_load, note_index);
    end
    loads = 0;
    repeat (5) begin
      tick();
      if (load_new_note === 1'b1) loads++;
    end
    n_checks++;
    if (loads != 0 || note_index !== 5'd0) begin
      n_fail++;
      $display("FAIL spur_after: loads=%0d idx=%0d required 0/0", loads, note_index);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int a = 0; a < 128; a++) rom_mem[a] = 12'd0;
    rom_mem[0]  = make_entry(6'd10, 6'd2);
    rom_mem[1]  = make_entry(6'd22, 6'd5);
    for (int i = 0; i < 32; i++) rom_mem[32 + i] = make_entry(6'(i + 1), 6'(i + 1));
    rom_mem[64] = make_entry(6'd33, 6'd7);
    rom_mem[65] = make_entry(6'd44, 6'd9);
    reset          = 1'b0;
    play           = 1'b0;
    song           = 2'd0;
    done_with_note = 1'b0;

    test_reset();
    test_basic();
    test_pause();
    test_song_change();
    test_full_song();
    test_reset_mid();
    test_spurious();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
